aes_key_expand: RTL
===================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter Nr, default 10, number of rounds; only the value 10 is supported.
REQ-002 SHALL have parameter Nk, default 4, key length in 32-bit words; only the value 4 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_in  input  128  cipher key, byte 0 in bits [127:120].
REQ-006 SHALL have port key_valid  input  1  key_in is valid this cycle.
REQ-007 SHALL have port key_ready  output  1  block can accept a key this cycle.
REQ-008 SHALL have port rk_idx  input  4  round-key index requested (0..10).
REQ-009 SHALL have port round_key  output  128  registered round key for rk_idx, for the datapath key input.
REQ-010 SHALL have port keys_ready  output  1  all 11 round keys are stored and valid.

Function
REQ-011 SHALL implement three states: IDLE, EXPAND, DONE.
REQ-012 SHALL drive key_ready=1 in IDLE and DONE, and key_ready=0 in EXPAND.
REQ-013 SHALL accept a key on a cycle where key_valid=1 and key_ready=1: store key_in as rk[0], set word counter cnt=1 and rcon=0x01, and enter EXPAND.
REQ-014 SHALL, in EXPAND, compute rk[cnt] from rk[cnt-1] in one cycle per FIPS-197 Nk=4: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}, and wi' = wi ^ w(i-1)' for i=1..3.
REQ-015 SHALL, after each EXPAND cycle, increment cnt and update rcon = xtime(rcon), i.e. reduced by 0x11B.
REQ-016 SHALL move to DONE on the cycle that writes rk[10]; keys_ready SHALL be 1 exactly 10 cycles after the accept edge and remain 1 in DONE.
REQ-017 SHALL, on a new key accepted in DONE, restart expansion; keys_ready SHALL drop to 0 on the following cycle.
REQ-018 SHALL update round_key one cycle after rk_idx is sampled (1-cycle read latency), in every state.
REQ-019 SHALL output zero on round_key when rk_idx > 10, or when the requested key has not yet been written since the last accept.
REQ-020 SHALL ignore key_valid during EXPAND; key_in is not captured.
REQ-021 SHALL store the 11 round keys in an internal 11x128 register array; no external memory.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, enter IDLE and clear cnt, rcon, the key array, round_key and keys_ready to 0.
REQ-023 SHALL, if rst is asserted mid-EXPAND, abort the expansion; no partial keys remain valid afterwards.
REQ-024 SHALL drive key_ready=1 on the first cycle after rst deasserts.

Structure
REQ-025 SHALL place the state encoding, the Rcon table, and constants Nr=10 and Nk=4 in shared package aes_pkg.
REQ-026 SHALL use one sub-module, aes_sbox (8-bit forward S-box), instantiated four times for SubWord.
REQ-027 SHALL use the same S-box contents as the datapath SubBytes.

Verification
REQ-028 SHALL cover the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: after keys_ready, rk_idx=1 -> a0fafe1788542cb123a339392a6c7605 and rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 SHALL cover timing: accept on cycle T -> keys_ready=0 at T+9 and keys_ready=1 at T+10; key_ready=0 during cycles T+1..T+10 exclusive of DONE.
REQ-030 SHALL cover reset at the 5th EXPAND cycle -> IDLE, keys_ready=0, round_key=0, key_ready=1 next cycle.
REQ-031 SHALL cover key_valid pulsed with key_in=all-ones during EXPAND -> ignored; rk_idx=10 still yields d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 SHALL cover key_in=0 accepted in DONE -> keys_ready falls and then rises 10 cycles later; rk_idx=1 -> 62636363626363636263636362636363.
REQ-033 SHALL cover rk_idx=11..15 -> round_key=0 one cycle later.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: controller states, round constants,
// the forward S-box table and GF(2^8) helpers.
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] RCON_TBL [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Single copy of the forward S-box, also used by the cipher SubBytes stage.
   localparam logic [7:0] SBOX_TBL [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8), reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit AES forward S-box, purely combinational table lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = SBOX_TBL[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys,
// one round key per cycle, with a registered random-access read port.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int Nr = NR,
   parameter int Nk = NK
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [3:0]   rk_idx,
   output logic [127:0] round_key,
   output logic         keys_ready
);

   localparam int NKEYS = Nr + 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [127:0]       r_rk [NKEYS];
   logic [NKEYS-1:0]   r_vld;
   logic [3:0]         r_cnt;
   logic [7:0]         r_rcon;
   logic [127:0]       r_round_key;
   logic               r_keys_ready;
   logic               w_key_ready;
   logic               w_accept;
   logic               w_rd_hit;
   logic [127:0]       w_prev;
   logic [127:0]       w_next;
   logic [31:0]        w_rot;
   logic [31:0]        w_sub;
   logic [31:0]        w_temp;
   logic [31:0]        w_word [Nk];

   assign w_prev = r_rk[r_cnt - 4'd1];
   assign w_rot  = {w_prev[23:0], w_prev[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[31-8*b -: 8]),
         .o_byte (w_sub[31-8*b -: 8])
      );
   end

   assign w_temp    = w_sub ^ {r_rcon, 24'h000000};
   assign w_word[0] = w_prev[127:96] ^ w_temp;

   // Each later word chains off the freshly computed word before it.
   for (genvar i = 1; i < Nk; i++) begin : g_chain
      assign w_word[i] = w_prev[127-32*i -: 32] ^ w_word[i-1];
   end

   for (genvar i = 0; i < Nk; i++) begin : g_pack
      assign w_next[127-32*i -: 32] = w_word[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_ready = 1'b1;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (key_valid) w_state_nxt = ST_EXPAND;
         end
         ST_EXPAND: begin
            w_key_ready = 1'b0;
            if (r_cnt == 4'(Nr)) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept = key_valid & w_key_ready;
   // Only keys written since the last accept are readable.
   assign w_rd_hit = (rk_idx <= 4'(Nr)) && r_vld[rk_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_rcon       <= '0;
         r_vld        <= '0;
         r_keys_ready <= 1'b0;
         r_round_key  <= '0;
         for (int i = 0; i < NKEYS; i++) r_rk[i] <= '0;
      end else begin
         r_round_key <= w_rd_hit ? r_rk[rk_idx] : '0;
         if (w_accept) begin
            r_rk[0]      <= key_in;
            r_vld        <= NKEYS'(1);
            r_cnt        <= 4'd1;
            r_rcon       <= RCON_TBL[0];
            r_keys_ready <= 1'b0;
         end else if (r_state == ST_EXPAND) begin
            r_rk[r_cnt]  <= w_next;
            r_vld[r_cnt] <= 1'b1;
            r_cnt        <= r_cnt + 4'd1;
            r_rcon       <= xtime(r_rcon);
            if (r_cnt == 4'(Nr)) r_keys_ready <= 1'b1;
         end
      end
   end

   assign key_ready  = w_key_ready;
   assign round_key  = r_round_key;
   assign keys_ready = r_keys_ready;

endmodule
